// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: FSM controller and datapath sharing one
// instruction/data memory port with a ready handshake.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          EXT_ISA  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        instr_done,
    output logic        trap,
    output logic [31:0] pc,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_IEXEC  = 4'd8;
    localparam logic [3:0] S_IWB    = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic [3:0]  state;
    logic [3:0]  dec_next;
    logic [31:0] ir, mdr, a, b, alu_out;
    logic [31:0] regs [32];
    logic [31:0] r_result, i_result;
    logic        funct_ok;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [31:0] sext, zext;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign sext  = {{16{ir[15]}}, ir[15:0]};
    assign zext  = {16'h0000, ir[15:0]};

    always_comb begin
        funct_ok = 1'b1;
        r_result = a + b;
        case (funct)
            6'h20: r_result = a + b;
            6'h22: r_result = a - b;
            6'h24: r_result = a & b;
            6'h25: r_result = a | b;
            6'h2A: r_result = {31'b0, $signed(a) < $signed(b)};
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_ANDI: i_result = a & zext;
            OP_ORI:  i_result = a | zext;
            default: i_result = a + sext;
        endcase
    end

    // Extended opcodes fall into TRAP when the core is built without them.
    always_comb begin
        case (op)
            OP_LW, OP_SW:    dec_next = S_MEMADR;
            OP_R:            dec_next = funct_ok ? S_EXEC : S_TRAP;
            OP_BEQ:          dec_next = S_BRANCH;
            OP_BNE:          dec_next = EXT_ISA ? S_BRANCH : S_TRAP;
            OP_ADDI:         dec_next = S_IEXEC;
            OP_ANDI, OP_ORI: dec_next = EXT_ISA ? S_IEXEC : S_TRAP;
            OP_J:            dec_next = S_JUMP;
            default:         dec_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            trap    <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir    <= mem_rdata;
                    pc    <= pc + 32'd4;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a       <= regs[rs];
                    b       <= regs[rt];
                    alu_out <= pc + {sext[29:0], 2'b00};
                    state   <= dec_next;
                end
                S_MEMADR: begin
                    alu_out <= a + sext;
                    state   <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: if (mem_ready) begin
                    mdr   <= mem_rdata;
                    state <= S_MEMWB;
                end
                S_MEMWB: begin
                    if (rt != 5'd0) regs[rt] <= mdr;
                    state <= S_FETCH;
                end
                S_MEMWR: if (mem_ready) state <= S_FETCH;
                S_EXEC: begin
                    alu_out <= r_result;
                    state   <= S_ALUWB;
                end
                S_ALUWB: begin
                    if (rd != 5'd0) regs[rd] <= alu_out;
                    state <= S_FETCH;
                end
                S_IEXEC: begin
                    alu_out <= i_result;
                    state   <= S_IWB;
                end
                S_IWB: begin
                    if (rt != 5'd0) regs[rt] <= alu_out;
                    state <= S_FETCH;
                end
                S_BRANCH: begin
                    if ((a == b) ^ (op == OP_BNE)) pc <= alu_out;
                    state <= S_FETCH;
                end
                S_JUMP: begin
                    pc    <= {pc[31:28], ir[25:0], 2'b00};
                    state <= S_FETCH;
                end
                S_TRAP:  trap  <= 1'b1;
                default: state <= S_TRAP;
            endcase
        end
    end

    // Reset gates the request so it drops the instant reset asserts.
    assign mem_req = reset && (state == S_FETCH || state == S_MEMRD
                               || state == S_MEMWR);
    assign mem_we    = reset && (state == S_MEMWR);
    assign mem_addr  = (state == S_FETCH) ? pc : alu_out;
    assign mem_wdata = b;

    assign instr_done = reset && (state == S_MEMWB || state == S_ALUWB
                                  || state == S_IWB || state == S_BRANCH
                                  || state == S_JUMP
                                  || (state == S_MEMWR && mem_ready));

    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'h0 : regs[dbg_raddr];
endmodule
